// File: rtl/vid_framecheck_pkg.sv
// Shared widths, error-flag layout and saturating counter helper for the video frame checker.
package vid_framecheck_pkg;

    localparam int unsigned ERR_W = 3;
    localparam int unsigned CNT_W = 16;

    // Sticky status layout, MSB first: {data, vert, horiz}
    typedef struct packed {
        logic data;
        logic vert;
        logic horiz;
    } err_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vid_poscount.sv
// Raster position tracker: x/y of the next expected beat, end-of-line/frame flags,
// and the frame geometry latched at start or end of frame.
module vid_poscount #(
    parameter int unsigned LGFRAME = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LGFRAME-1:0] width,
    input  logic [LGFRAME-1:0] height,
    input  logic               load,
    input  logic               adv,
    input  logic               drop,
    output logic [LGFRAME-1:0] x,
    output logic [LGFRAME-1:0] y,
    output logic               hexp_c,
    output logic               vexp_c
);

    logic [LGFRAME-1:0] wl;
    logic [LGFRAME-1:0] hl;

    assign hexp_c = (x == wl - LGFRAME'(1));
    assign vexp_c = (y == hl - LGFRAME'(1));

    // load marks pixel (0,0) as consumed, so the next beat is x=1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x  <= '0;
            y  <= '0;
            wl <= '0;
            hl <= '0;
        end else if (load) begin
            wl <= width;
            hl <= height;
            x  <= LGFRAME'(1);
            y  <= '0;
        end else if (drop) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (hexp_c) begin
                x <= '0;
                if (vexp_c) begin
                    y  <= '0;
                    wl <= width;
                    hl <= height;
                end else begin
                    y <= y + LGFRAME'(1);
                end
            end else begin
                x <= x + LGFRAME'(1);
            end
        end
    end

endmodule

// File: rtl/vid_framecheck.sv
// AXI video-stream sink that locks to frame boundaries, checks TLAST/TUSER framing
// and pixel data, and reports measured geometry, good-frame count and sticky errors.
module vid_framecheck
    import vid_framecheck_pkg::*;
#(
    parameter int unsigned     PW               = 24,
    parameter int unsigned     LGFRAME          = 12,
    parameter logic [PW-1:0]   PIXEL            = '0,
    parameter bit              OPT_TUSER_IS_SOF = 1'b1,
    parameter bit              OPT_CHECK_DATA   = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               S_VID_VALID,
    output logic               S_VID_READY,
    input  logic [PW-1:0]      S_VID_DATA,
    input  logic               S_VID_LAST,
    input  logic               S_VID_USER,
    input  logic [LGFRAME-1:0] i_width,
    input  logic [LGFRAME-1:0] i_height,
    input  logic               i_stall,
    input  logic               i_clear,
    output logic               o_locked,
    output logic [LGFRAME-1:0] o_meas_width,
    output logic [LGFRAME-1:0] o_meas_height,
    output logic [CNT_W-1:0]   o_frames,
    output logic [ERR_W-1:0]   o_err,
    output logic [CNT_W-1:0]   o_err_count
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic               ready_r;
    logic               last_q;
    logic [LGFRAME-1:0] x;
    logic [LGFRAME-1:0] y;
    logic               hexp_c;
    logic               vexp_c;
    logic               load;
    logic               adv;
    logic               drop;
    logic               beat;
    logic               origin;
    logic               sof;
    logic               h_err;
    logic               v_err;
    logic               d_err;
    err_t               err;
    err_t               err_n;
    err_t               new_err;
    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W-1:0]   err_cnt_n;
    logic [CNT_W-1:0]   frames;
    logic [CNT_W-1:0]   frames_n;
    logic [LGFRAME-1:0] meas_w;
    logic [LGFRAME-1:0] meas_w_n;
    logic [LGFRAME-1:0] meas_h;
    logic [LGFRAME-1:0] meas_h_n;

    assign S_VID_READY = ready_r && !i_stall;
    assign beat        = S_VID_VALID && S_VID_READY;
    assign origin      = (x == '0) && (y == '0);

    // In end-of-frame mode the beat after LAST opens the next frame
    assign sof   = OPT_TUSER_IS_SOF ? S_VID_USER : last_q;
    assign h_err = OPT_TUSER_IS_SOF ? (S_VID_LAST != hexp_c) : (S_VID_USER != hexp_c);
    assign v_err = OPT_TUSER_IS_SOF ? (S_VID_USER != origin)
                                    : (S_VID_LAST != (hexp_c && vexp_c));
    assign d_err = OPT_CHECK_DATA && (S_VID_DATA != PIXEL);

    vid_poscount #(
        .LGFRAME (LGFRAME)
    ) u_pos (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .width  (i_width),
        .height (i_height),
        .load   (load),
        .adv    (adv),
        .drop   (drop),
        .x      (x),
        .y      (y),
        .hexp_c (hexp_c),
        .vexp_c (vexp_c)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= SEARCH;
            ready_r <= 1'b0;
            last_q  <= 1'b0;
            err     <= '0;
            err_cnt <= '0;
            frames  <= '0;
            meas_w  <= '0;
            meas_h  <= '0;
        end else begin
            state   <= state_n;
            ready_r <= 1'b1;
            if (beat) begin
                last_q <= S_VID_LAST;
            end
            err     <= err_n;
            err_cnt <= err_cnt_n;
            frames  <= frames_n;
            meas_w  <= meas_w_n;
            meas_h  <= meas_h_n;
        end
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        adv      = 1'b0;
        drop     = 1'b0;
        new_err  = '0;
        frames_n = frames;
        meas_w_n = meas_w;
        meas_h_n = meas_h;

        if (beat) begin
            unique case (state)
                SEARCH: begin
                    if (sof) begin
                        load    = 1'b1;
                        state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    new_err.horiz = h_err;
                    new_err.vert  = v_err;
                    new_err.data  = d_err;
                    if (h_err || v_err) begin
                        // A stray start-of-frame marker is trusted as the new frame origin
                        if (OPT_TUSER_IS_SOF && S_VID_USER) begin
                            load = 1'b1;
                        end else begin
                            drop    = 1'b1;
                            state_n = SEARCH;
                        end
                    end else begin
                        adv = 1'b1;
                        if (hexp_c && !d_err) begin
                            meas_w_n = x + LGFRAME'(1);
                            if (vexp_c) begin
                                meas_h_n = y + LGFRAME'(1);
                                frames_n = frames + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        // A clear coinciding with a new error leaves only that error recorded
        err_n     = i_clear ? err_t'('0) : err;
        err_cnt_n = i_clear ? '0 : err_cnt;
        if (|new_err) begin
            err_n     = err_n | new_err;
            err_cnt_n = i_clear ? CNT_W'(1) : sat_inc(err_cnt);
        end
    end

    assign o_locked      = (state == LOCKED);
    assign o_meas_width  = meas_w;
    assign o_meas_height = meas_h;
    assign o_frames      = frames;
    assign o_err         = err;
    assign o_err_count   = err_cnt;

endmodule

// File: tb/tb_vid_framecheck.sv
// Scenario bench for vid_framecheck: start-of-frame (dut) and end-of-frame (dut0) framing modes.
module tb_vid_framecheck;

    localparam int unsigned PW = 24;
    localparam int unsigned LG = 12;
    localparam logic [PW-1:0] PIX = 24'h00A5C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [LG-1:0] w_in = LG'(8);
    logic [LG-1:0] h_in = LG'(4);
    logic          stall = 1'b0;

    logic          valid = 1'b0, last = 1'b0, user = 1'b0, clr = 1'b0, ready;
    logic [PW-1:0] data = '0;
    logic          locked;
    logic [LG-1:0] mw, mh;
    logic [15:0]   frames, cnt;
    logic [2:0]    err;

    logic          valid0 = 1'b0, last0 = 1'b0, user0 = 1'b0, clr0 = 1'b0, ready0;
    logic [PW-1:0] data0 = '0;
    logic          locked0;
    logic [LG-1:0] mw0, mh0;
    logic [15:0]   frames0, cnt0;
    logic [2:0]    err0;

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;
    bit stall_en = 1'b0;
    logic [15:0] prev_frames = '0;

    typedef struct {
        int frames;
        int mw;
        int mh;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    vid_framecheck #(
        .PW(PW), .LGFRAME(LG), .PIXEL(PIX), .OPT_TUSER_IS_SOF(1'b1), .OPT_CHECK_DATA(1'b1)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .S_VID_VALID(valid), .S_VID_READY(ready), .S_VID_DATA(data),
        .S_VID_LAST(last), .S_VID_USER(user),
        .i_width(w_in), .i_height(h_in), .i_stall(stall), .i_clear(clr),
        .o_locked(locked), .o_meas_width(mw), .o_meas_height(mh),
        .o_frames(frames), .o_err(err), .o_err_count(cnt)
    );

    vid_framecheck #(
        .PW(PW), .LGFRAME(LG), .PIXEL(PIX), .OPT_TUSER_IS_SOF(1'b0), .OPT_CHECK_DATA(1'b1)
    ) dut0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .S_VID_VALID(valid0), .S_VID_READY(ready0), .S_VID_DATA(data0),
        .S_VID_LAST(last0), .S_VID_USER(user0),
        .i_width(w_in), .i_height(h_in), .i_stall(stall), .i_clear(clr0),
        .o_locked(locked0), .o_meas_width(mw0), .o_meas_height(mh0),
        .o_frames(frames0), .o_err(err0), .o_err_count(cnt0)
    );

    // Scoreboard: every completed frame on dut must match the next queued expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_frames = '0;
        end else if (frames !== prev_frames) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL frame_unexpected frames=%0d", frames);
            end else begin
                mon_e = exp_q.pop_front();
                if ({frames, mw, mh} !== {16'(mon_e.frames), LG'(mon_e.mw), LG'(mon_e.mh)}) begin
                    failures++;
                    $display("FAIL frame_done got frames=%0d w=%0d h=%0d exp frames=%0d w=%0d h=%0d",
                             frames, mw, mh, mon_e.frames, mon_e.mw, mon_e.mh);
                end
            end
            prev_frames = frames;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input int w, input int h);
        exp_t e;
        exp_frames++;
        e.frames = exp_frames;
        e.mw = w;
        e.mh = h;
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1; holds the beat until accepted
    task automatic drive_beat(input bit sel, input logic [PW-1:0] d, input logic l, input logic u);
        bit got = 1'b0;
        if (stall_en && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        if (sel) begin
            valid0 = 1'b1; data0 = d; last0 = l; user0 = u;
        end else begin
            valid = 1'b1; data = d; last = l; user = u;
        end
        for (int n = 0; n < 200 && !got; n++) begin
            stall = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            got = sel ? ready0 : ready;
            @(posedge clk); #1;
        end
        valid = 1'b0; valid0 = 1'b0; stall = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout sel=%0d ready never seen", sel);
        end
    endtask

    // Raster from (sx,sy) to (ex,ey); fx/fy flips LAST, dx/dy corrupts data (-1 = none)
    task automatic send_span(input bit sel, input int w, input int h,
                             input int sx, input int sy, input int ex, input int ey,
                             input int fx, input int fy, input int dx, input int dy);
        logic l, u, eol, eof;
        logic [PW-1:0] d;
        for (int yy = sy; yy <= ey; yy++) begin
            for (int xx = (yy == sy) ? sx : 0; xx <= ((yy == ey) ? ex : w - 1); xx++) begin
                eol = (xx == w - 1);
                eof = eol && (yy == h - 1);
                l = sel ? eof : eol;
                u = sel ? eol : (xx == 0 && yy == 0);
                if (xx == fx && yy == fy) l = !l;
                d = (xx == dx && yy == dy) ? (PIX ^ PW'(1)) : PIX;
                drive_beat(sel, d, l, u);
            end
        end
    endtask

    task automatic good_frame(input bit sel, input int w, input int h);
        send_span(sel, w, h, 0, 0, w - 1, h - 1, -1, -1, -1, -1);
    endtask

    task automatic pulse_clear(input bit sel);
        if (sel) clr0 = 1'b1; else clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; clr0 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({ready, locked, mw, mh, frames, err, cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b lock=%b w=%0d h=%0d fr=%0d err=%b cnt=%0d exp all 0",
                     ready, locked, mw, mh, frames, err, cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=0", ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({ready, ready0} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_clock got=%b%b exp=11", ready, ready0);
        end
    endtask

    task automatic test_basic();
        for (int f = 0; f < 3; f++) begin
            push_frame(8, 4);
            good_frame(1'b0, 8, 4);
        end
        checks++;
        if ({frames, mw, mh, err, cnt, locked} !== {16'd3, LG'(8), LG'(4), 3'b000, 16'd0, 1'b1}) begin
            failures++;
            $display("FAIL basic got fr=%0d w=%0d h=%0d err=%b cnt=%0d lock=%b exp 3/8/4/000/0/1",
                     frames, mw, mh, err, cnt, locked);
        end
    endtask

    task automatic test_stall();
        stall_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame(8, 4);
            good_frame(1'b0, 8, 4);
        end
        stall_en = 1'b0;
        checks++;
        if ({frames, mw, mh, err, cnt} !== {16'd6, LG'(8), LG'(4), 3'b000, 16'd0}) begin
            failures++;
            $display("FAIL stall got fr=%0d w=%0d h=%0d err=%b cnt=%0d exp 6/8/4/000/0",
                     frames, mw, mh, err, cnt);
        end
    endtask

    task automatic test_resize();
        push_frame(8, 4);
        send_span(1'b0, 8, 4, 0, 0, 7, 1, -1, -1, -1, -1);
        w_in = LG'(6); h_in = LG'(3);
        send_span(1'b0, 8, 4, 0, 2, 7, 3, -1, -1, -1, -1);
        push_frame(6, 3);
        send_span(1'b0, 6, 3, 0, 0, 5, 0, -1, -1, -1, -1);
        w_in = LG'(8); h_in = LG'(4);
        send_span(1'b0, 6, 3, 0, 1, 5, 2, -1, -1, -1, -1);
        push_frame(8, 4);
        good_frame(1'b0, 8, 4);
        checks++;
        if ({frames, err, cnt} !== {16'd9, 3'b000, 16'd0}) begin
            failures++;
            $display("FAIL resize got fr=%0d err=%b cnt=%0d exp 9/000/0", frames, err, cnt);
        end
    endtask

    task automatic test_midframe_start();
        do_reset();
        send_span(1'b0, 8, 4, 5, 2, 7, 3, -1, -1, -1, -1);
        checks++;
        if ({locked, err, cnt} !== {1'b0, 3'b000, 16'd0}) begin
            failures++;
            $display("FAIL search_quiet got lock=%b err=%b cnt=%0d exp 0/000/0", locked, err, cnt);
        end
        send_span(1'b0, 8, 4, 0, 0, 0, 0, -1, -1, -1, -1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_on_sof got=%b exp=1", locked);
        end
        push_frame(8, 4);
        send_span(1'b0, 8, 4, 1, 0, 7, 3, -1, -1, -1, -1);
        checks++;
        if (frames !== 16'd1) begin
            failures++;
            $display("FAIL first_frame got=%0d exp=1", frames);
        end
    endtask

    task automatic test_hdrop();
        send_span(1'b0, 8, 4, 0, 0, 7, 3, 7, 1, -1, -1);
        checks++;
        if ({err, cnt, locked} !== {3'b001, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL hdrop got err=%b cnt=%0d lock=%b exp 001/1/0", err, cnt, locked);
        end
        push_frame(8, 4);
        good_frame(1'b0, 8, 4);
        checks++;
        if ({locked, err, frames} !== {1'b1, 3'b001, 16'd2}) begin
            failures++;
            $display("FAIL hdrop_relock got lock=%b err=%b fr=%0d exp 1/001/2", locked, err, frames);
        end
        pulse_clear(1'b0);
        checks++;
        if ({err, cnt} !== {3'b000, 16'd0}) begin
            failures++;
            $display("FAIL clear got err=%b cnt=%0d exp 000/0", err, cnt);
        end
    endtask

    task automatic test_resync();
        send_span(1'b0, 8, 4, 0, 0, 2, 1, -1, -1, -1, -1);
        drive_beat(1'b0, PIX, 1'b0, 1'b1);
        checks++;
        if ({err, cnt, locked} !== {3'b010, 16'd1, 1'b1}) begin
            failures++;
            $display("FAIL resync got err=%b cnt=%0d lock=%b exp 010/1/1", err, cnt, locked);
        end
        push_frame(8, 4);
        send_span(1'b0, 8, 4, 1, 0, 7, 3, -1, -1, -1, -1);
        checks++;
        if ({frames, err, cnt} !== {16'd3, 3'b010, 16'd1}) begin
            failures++;
            $display("FAIL resync_frame got fr=%0d err=%b cnt=%0d exp 3/010/1", frames, err, cnt);
        end
        pulse_clear(1'b0);
    endtask

    task automatic test_eof_mode();
        do_reset();
        good_frame(1'b1, 8, 4);
        good_frame(1'b1, 8, 4);
        checks++;
        if ({frames0, mw0, mh0, err0, locked0} !== {16'd1, LG'(8), LG'(4), 3'b000, 1'b1}) begin
            failures++;
            $display("FAIL eof_lock got fr=%0d w=%0d h=%0d err=%b lock=%b exp 1/8/4/000/1",
                     frames0, mw0, mh0, err0, locked0);
        end
        send_span(1'b1, 8, 4, 0, 0, 7, 2, 7, 2, -1, -1);
        checks++;
        if ({err0, cnt0, locked0} !== {3'b010, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL eof_vert got err=%b cnt=%0d lock=%b exp 010/1/0", err0, cnt0, locked0);
        end
        send_span(1'b1, 8, 4, 0, 3, 7, 3, -1, -1, -1, -1);
        good_frame(1'b1, 8, 4);
        checks++;
        if ({frames0, err0, cnt0, locked0} !== {16'd2, 3'b010, 16'd2, 1'b1}) begin
            failures++;
            $display("FAIL eof_recover got fr=%0d err=%b cnt=%0d lock=%b exp 2/010/2/1",
                     frames0, err0, cnt0, locked0);
        end
    endtask

    task automatic test_data_and_reset();
        push_frame(8, 4);
        good_frame(1'b0, 8, 4);
        send_span(1'b0, 8, 4, 0, 0, 3, 1, -1, -1, 3, 1);
        checks++;
        if ({err, cnt, locked} !== {3'b100, 16'd1, 1'b1}) begin
            failures++;
            $display("FAIL data_err got err=%b cnt=%0d lock=%b exp 100/1/1", err, cnt, locked);
        end
        clr = 1'b1;
        drive_beat(1'b0, PIX ^ PW'(1), 1'b0, 1'b0);
        clr = 1'b0;
        checks++;
        if ({err, cnt} !== {3'b100, 16'd1}) begin
            failures++;
            $display("FAIL clear_vs_error got err=%b cnt=%0d exp 100/1", err, cnt);
        end
        pulse_clear(1'b0);
        send_span(1'b0, 8, 4, 5, 1, 7, 1, 7, 1, 7, 1);
        checks++;
        if ({err, cnt, locked} !== {3'b101, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL combined_err got err=%b cnt=%0d lock=%b exp 101/1/0", err, cnt, locked);
        end
        push_frame(8, 4);
        good_frame(1'b0, 8, 4);
        send_span(1'b0, 8, 4, 0, 0, 2, 1, -1, -1, -1, -1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, locked, mw, mh, frames, err, cnt} !== '0) begin
            failures++;
            $display("FAIL midframe_reset got rdy=%b lock=%b w=%0d h=%0d fr=%0d err=%b cnt=%0d exp all 0",
                     ready, locked, mw, mh, frames, err, cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_resize();
        test_midframe_start();
        test_hdrop();
        test_resync();
        test_eof_mode();
        test_data_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
